// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory arbiter and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arbState_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // A single requester still needs a one-bit index.
  function automatic int grantWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshake plus memory-side bus of the arbiter; slave = arbiter, master = requesters/memory.
// The ReqLock port exists only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 2,
  parameter int NREQ = 2,
  parameter int GW   = grantWidth(NREQ)
);

  logic [NREQ-1:0]   ReqValid;
  logic [NREQ-1:0]   ReqRW;
  logic [NREQ*M-1:0] ReqAddr;
  logic [NREQ*N-1:0] ReqWData;
`ifdef MEM_ARB_LOCK_EN
  logic [NREQ-1:0]   ReqLock;
`endif
  logic [NREQ-1:0]   ReqReady;
  logic [NREQ-1:0]   RspValid;
  logic [N-1:0]      RspData;
  logic [M-1:0]      MemSelect;
  logic              MemRW;
  logic              MemEn;
  logic [N-1:0]      MemWData;
  logic [N-1:0]      MemRData;
  logic              Busy;
  logic [GW-1:0]     GrantId;

  modport slave (
    input  ReqValid, ReqRW, ReqAddr, ReqWData, MemRData,
`ifdef MEM_ARB_LOCK_EN
    input  ReqLock,
`endif
    output ReqReady, RspValid, RspData, MemSelect, MemRW, MemEn, MemWData, Busy, GrantId
  );

  modport master (
    output ReqValid, ReqRW, ReqAddr, ReqWData, MemRData,
`ifdef MEM_ARB_LOCK_EN
    output ReqLock,
`endif
    input  ReqReady, RspValid, RspData, MemSelect, MemRW, MemEn, MemWData, Busy, GrantId
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from pointer+1, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GW   = grantWidth(NREQ)
) (
  input  logic [NREQ-1:0] reqVec,
  input  logic [GW-1:0]   pointer,
  output logic [NREQ-1:0] grant,
  output logic [GW-1:0]   grantIdx,
  output logic            anyValid
);

  int idx;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyValid = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(pointer) + k) % NREQ;
      if (!anyValid && reqVec[idx]) begin
        anyValid      = 1'b1;
        grant[idx]    = 1'b1;
        grantIdx      = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port word memory between NREQ requesters with a 4-cycle IDLE/ACCESS/CAPTURE/RESP sequence.
// Define MEM_ARB_LOCK_EN to add ReqLock, which lets a requester hold the grant for atomic sequences.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 2,
  parameter int NREQ = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  mem_arbiter_if.slave  bus
);

  localparam int GW = grantWidth(NREQ);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ACCESS  = ACCESS;
  localparam logic [1:0] S_CAPTURE = CAPTURE;
  localparam logic [1:0] S_RESP    = RESP;

  logic [1:0]      state;
  logic [GW-1:0]   pointer;
  logic [GW-1:0]   grantId;
  logic            latRW;
  logic [M-1:0]    latAddr;
  logic [N-1:0]    latWData;
  logic [N-1:0]    rspData;

  logic [NREQ-1:0] pickGrant;
  logic [GW-1:0]   pickIdx;
  logic            pickAny;
  logic [NREQ-1:0] winGrant;
  logic [GW-1:0]   winIdx;
  logic            winAny;
  logic            accept;

`ifdef MEM_ARB_LOCK_EN
  logic            lockHeld;
`endif

  rr_picker #(.NREQ(NREQ), .GW(GW)) picker (
    .reqVec   (bus.ReqValid),
    .pointer  (pointer),
    .grant    (pickGrant),
    .grantIdx (pickIdx),
    .anyValid (pickAny)
  );

  // A held lock overrides rotation while the locking requester stays valid.
  always_comb begin
    winGrant = pickGrant;
    winIdx   = pickIdx;
    winAny   = pickAny;
`ifdef MEM_ARB_LOCK_EN
    if (lockHeld && bus.ReqValid[grantId]) begin
      winGrant          = '0;
      winGrant[grantId] = 1'b1;
      winIdx            = grantId;
      winAny            = 1'b1;
    end
`endif
  end

  assign accept = (state == S_IDLE) && winAny && !Reset;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      pointer  <= GW'(NREQ - 1);
      grantId  <= '0;
      latRW    <= RW_READ;
      latAddr  <= '0;
      latWData <= '0;
      rspData  <= '0;
`ifdef MEM_ARB_LOCK_EN
      lockHeld <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (winAny) begin
            latRW    <= bus.ReqRW[winIdx];
            latAddr  <= bus.ReqAddr[int'(winIdx)*M +: M];
            latWData <= bus.ReqWData[int'(winIdx)*N +: N];
            grantId  <= winIdx;
            pointer  <= winIdx;
            state    <= S_ACCESS;
`ifdef MEM_ARB_LOCK_EN
            lockHeld <= bus.ReqLock[winIdx];
`endif
          end else begin
`ifdef MEM_ARB_LOCK_EN
            lockHeld <= 1'b0;
`endif
          end
        end
        S_ACCESS: state <= S_CAPTURE;
        S_CAPTURE: begin
          if (latRW == RW_READ) rspData <= bus.MemRData;
          state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ReqReady  = accept ? winGrant : '0;
  assign bus.RspValid  = (state == S_RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << grantId) : '0;
  assign bus.RspData   = rspData;
  assign bus.MemEn     = (state == S_ACCESS);
  assign bus.MemSelect = latAddr;
  assign bus.MemRW     = latRW;
  assign bus.MemWData  = latWData;
  assign bus.Busy      = (state != S_IDLE);
  assign bus.GrantId   = grantId;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table for the main paths plus hand sequences for multi-cycle cases.
// The lock sequence runs only when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   cycleCount = 0;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cycleCount <= cycleCount + 1;

  mem_arbiter_if #(.N(8), .M(2), .NREQ(2)) bus ();

  mem_arbiter #(.N(8), .M(2), .NREQ(2)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Behavioural memory: write on strobe, read data registered one cycle after the strobe.
  logic [7:0] mem [4] = '{default: 8'h00};
  always @(posedge Clock) begin
    if (bus.MemEn) begin
      if (bus.MemRW) mem[bus.MemSelect] <= bus.MemWData;
      else           bus.MemRData <= mem[bus.MemSelect];
    end
  end

  typedef struct {
    logic       rst;
    logic [1:0] v, rw, a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] eReady, eRsp;
    logic       eEn, eRW;
    logic [1:0] eSel;
    logic [7:0] eWD;
    logic       eBusy, eGrant;
    logic [7:0] eRsd;
  } vec_t;

  vec_t vecs [33];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic nextCycle;
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] v, input logic [1:0] rw,
                               input logic [1:0] a0, input logic [1:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
    Reset        = rst;
    bus.ReqValid = v;
    bus.ReqRW    = rw;
    bus.ReqAddr  = {a1, a0};
    bus.ReqWData = {d1, d0};
  endtask

  task automatic checkOutput(input int i);
    check($sformatf("v%0d_ready", i),   32'(bus.ReqReady),  32'(vecs[i].eReady));
    check($sformatf("v%0d_rsp", i),     32'(bus.RspValid),  32'(vecs[i].eRsp));
    check($sformatf("v%0d_en", i),      32'(bus.MemEn),     32'(vecs[i].eEn));
    check($sformatf("v%0d_rw", i),      32'(bus.MemRW),     32'(vecs[i].eRW));
    check($sformatf("v%0d_sel", i),     32'(bus.MemSelect), 32'(vecs[i].eSel));
    check($sformatf("v%0d_wdata", i),   32'(bus.MemWData),  32'(vecs[i].eWD));
    check($sformatf("v%0d_busy", i),    32'(bus.Busy),      32'(vecs[i].eBusy));
    check($sformatf("v%0d_grant", i),   32'(bus.GrantId),   32'(vecs[i].eGrant));
    check($sformatf("v%0d_rspdata", i), 32'(bus.RspData),   32'(vecs[i].eRsd));
  endtask

  task automatic waitReady(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge Clock);
      if (bus.ReqReady[idx]) ok = 1'b1;
      else nextCycle;
    end
  endtask

  task automatic waitRsp(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge Clock);
      if (bus.RspValid[idx]) ok = 1'b1;
      else nextCycle;
    end
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      nextCycle;
      @(negedge Clock);
      if (!bus.Busy) ok = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int t0, r1, e1;
    applyStimulus(1'b1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    bus.MemRData = 8'h00;
`ifdef MEM_ARB_LOCK_EN
    bus.ReqLock = 2'b00;
`endif

    // rst, v, rw, a0, a1, d0, d1 | ready, rsp, en, rw, sel, wdata, busy, grant, rspdata
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    // requester 0 writes A5 to addr 2, then reads it back
    vecs[2]  = '{1'b0, 2'b01, 2'b01, 2'd2, 2'd0, 8'hA5, 8'h00, 2'b01, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 1'b1, 2'd2, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 2'b00, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 2'b00, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 2'b00, 2'b01, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 2'b01, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 2'b00, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 2'b00, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 2'b00, 2'b01, 1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0, 8'hA5};
    vecs[10] = '{1'b0, 2'b00, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 8'hA5};
    // requester 1 write interrupted by a two-cycle reset during ACCESS
    vecs[11] = '{1'b0, 2'b10, 2'b10, 2'd0, 2'd1, 8'h00, 8'h5A, 2'b10, 2'b00, 1'b0, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[12] = '{1'b1, 2'b00, 2'b00, 2'd0, 2'd1, 8'h00, 8'h5A, 2'b00, 2'b00, 1'b1, 1'b1, 2'd1, 8'h5A, 1'b1, 1'b1, 8'hA5};
    vecs[13] = '{1'b1, 2'b00, 2'b00, 2'd0, 2'd1, 8'h00, 8'h5A, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[14] = '{1'b0, 2'b00, 2'b00, 2'd0, 2'd1, 8'h00, 8'h5A, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[15] = '{1'b0, 2'b00, 2'b00, 2'd0, 2'd1, 8'h00, 8'h5A, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    // contention: req0 writes 11 to addr 0, req1 reads addr 2; grants alternate 0,1,0,1
    vecs[16] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b01, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[17] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b00, 1'b1, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 8'h00};
    vecs[18] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 8'h00};
    vecs[19] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b01, 1'b0, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 8'h00};
    vecs[20] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b10, 2'b00, 1'b0, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 8'h00};
    vecs[21] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[22] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[23] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b10, 1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[24] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b01, 2'b00, 1'b0, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 8'hA5};
    vecs[25] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b00, 1'b1, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 8'hA5};
    vecs[26] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 8'hA5};
    vecs[27] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b01, 1'b0, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 8'hA5};
    vecs[28] = '{1'b0, 2'b11, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b10, 2'b00, 1'b0, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 8'hA5};
    vecs[29] = '{1'b0, 2'b00, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[30] = '{1'b0, 2'b00, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[31] = '{1'b0, 2'b00, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b10, 1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[32] = '{1'b0, 2'b00, 2'b01, 2'd0, 2'd2, 8'h11, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 8'hA5};

    for (int i = 0; i < 33; i++) begin
      nextCycle;
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].rw, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      @(negedge Clock);
      checkOutput(i);
    end
    check("mem_write_before_reset", 32'(mem[1]), 32'h5A);
    check("mem_contention_write", 32'(mem[0]), 32'h11);

    // Withdrawal: requester 1 pulses valid for one busy cycle and must never be served.
    nextCycle;
    applyStimulus(1'b0, 2'b01, 2'b01, 2'd3, 2'd1, 8'h77, 8'hEE);
    @(negedge Clock);
    check("wd_accept0", 32'(bus.ReqReady), 32'h1);
    nextCycle;
    applyStimulus(1'b0, 2'b10, 2'b10, 2'd3, 2'd1, 8'h77, 8'hEE);
    r1 = 0;
    e1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        nextCycle;
        if (i == 1) applyStimulus(1'b0, 2'b00, 2'b00, 2'd3, 2'd1, 8'h77, 8'hEE);
      end
      @(negedge Clock);
      if (bus.ReqReady[1]) r1++;
      if (bus.MemEn && bus.MemSelect == 2'd1) e1++;
    end
    check("wd_no_grant1", 32'(r1), 32'h0);
    check("wd_no_access1", 32'(e1), 32'h0);
    check("wd_mem3", 32'(mem[3]), 32'h77);
    check("wd_mem1_kept", 32'(mem[1]), 32'h5A);

    // Re-request during RESP with the other requester idle.
    nextCycle;
    applyStimulus(1'b0, 2'b01, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    waitReady(0, 4, ok);
    check("rr1_ready0", 32'(ok), 32'h1);
    t0 = cycleCount;
    nextCycle;
    applyStimulus(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    waitRsp(0, 6, ok);
    check("rr1_rsp0", 32'(ok), 32'h1);
    check("rr1_latency", 32'(cycleCount - t0), 32'd3);
    check("rr1_rspdata", 32'(bus.RspData), 32'h11);
    applyStimulus(1'b0, 2'b01, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    waitReady(0, 4, ok);
    check("rr1_reready0", 32'(ok), 32'h1);
    check("rr1_spacing", 32'(cycleCount - t0), 32'd4);
    nextCycle;
    applyStimulus(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    waitIdle(8, ok);
    check("rr1_idle", 32'(ok), 32'h1);

    // Re-request during RESP while requester 1 waits: requester 1 goes first.
    nextCycle;
    applyStimulus(1'b0, 2'b01, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00);
    waitReady(0, 4, ok);
    check("rr2_ready0", 32'(ok), 32'h1);
    nextCycle;
    applyStimulus(1'b0, 2'b10, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00);
    waitRsp(0, 6, ok);
    check("rr2_rsp0", 32'(ok), 32'h1);
    applyStimulus(1'b0, 2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00);
    @(negedge Clock);
    check("rr2_req1_first", 32'(bus.ReqReady), 32'h2);
    t0 = cycleCount;
    nextCycle;
    applyStimulus(1'b0, 2'b01, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00);
    waitRsp(1, 6, ok);
    check("rr2_rsp1", 32'(ok), 32'h1);
    check("rr2_rspdata1", 32'(bus.RspData), 32'h5A);
    waitReady(0, 4, ok);
    check("rr2_ready0_after", 32'(ok), 32'h1);
    check("rr2_spacing", 32'(cycleCount - t0), 32'd4);
    nextCycle;
    applyStimulus(1'b0, 2'b00, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00);
    waitIdle(8, ok);
    check("rr2_idle", 32'(ok), 32'h1);

`ifdef MEM_ARB_LOCK_EN
    // Locked read-modify-write by requester 0 while requester 1 is waiting.
    nextCycle;
    applyStimulus(1'b1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    nextCycle;
    applyStimulus(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    nextCycle;
    bus.ReqLock = 2'b01;
    applyStimulus(1'b0, 2'b11, 2'b10, 2'd1, 2'd2, 8'h00, 8'h99);
    waitReady(0, 4, ok);
    check("lock_ready0", 32'(ok), 32'h1);
    nextCycle;
    applyStimulus(1'b0, 2'b11, 2'b11, 2'd1, 2'd2, 8'h3C, 8'h99);
    waitRsp(0, 6, ok);
    check("lock_rsp0", 32'(ok), 32'h1);
    check("lock_readdata", 32'(bus.RspData), 32'h5A);
    @(negedge Clock);
    check("lock_regrant0", 32'(bus.ReqReady), 32'h1);
    nextCycle;
    bus.ReqLock = 2'b00;
    applyStimulus(1'b0, 2'b10, 2'b11, 2'd1, 2'd2, 8'h3C, 8'h99);
    waitReady(1, 8, ok);
    check("lock_then_ready1", 32'(ok), 32'h1);
    nextCycle;
    applyStimulus(1'b0, 2'b00, 2'b00, 2'd1, 2'd2, 8'h00, 8'h00);
    waitIdle(8, ok);
    check("lock_idle", 32'(ok), 32'h1);
    check("lock_mem1", 32'(mem[1]), 32'h3C);
    check("lock_mem2", 32'(mem[2]), 32'h99);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port word memory (N-bit data, M-bit select) between NREQ requesters, e.g. the executor and a loader/debug port.
- Each requester gets a request/ready/response handshake.
- The arbiter owns the memory's Select/RW/enable and its write and read data.
- The top level converts MemWData/MemRData/MemEn into the memory's bidirectional data bus.

Parameters:
- N, 8, data word width
- M, 2, address width; memory depth 2**M
- NREQ, 2, number of requesters (2..8)

Ports:
- Clock  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- ReqValid  input  NREQ  request pending per requester
- ReqRW  input  NREQ  per-requester access type: 1 = write, 0 = read
- ReqAddr  input  NREQ*M  per-requester address; slice i = bits [i*M +: M]
- ReqWData  input  NREQ*N  per-requester write data; slice i = bits [i*N +: N]
- ReqReady  output  NREQ  one-hot acceptance strobe
- RspValid  output  NREQ  one-hot completion strobe
- RspData  output  N  read data, valid while RspValid is high
- MemSelect  output  M  memory address
- MemRW  output  1  memory access type, same encoding as ReqRW
- MemEn  output  1  memory access strobe
- MemWData  output  N  data driven onto the memory bus when MemEn & MemRW
- MemRData  input  N  memory read data, valid one cycle after a read strobe
- Busy  output  1  high whenever state != IDLE
- GrantId  output  clog2(NREQ)  index of the current/last granted requester

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all outputs 0; RspData = 0; GrantId = 0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE -> ACCESS -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - If any ReqValid is high, the winner g is the first set bit scanning upward from pointer+1, wrapping modulo NREQ.
  - ReqReady[g] is high combinationally in this cycle.
  - At the clock edge: latch ReqRW[g], ReqAddr slice g and ReqWData slice g; set GrantId = g and pointer = g; go to ACCESS.
  - If no ReqValid is high, stay in IDLE with all strobes low.
- ACCESS:
  - MemEn = 1; MemSelect, MemRW and MemWData are driven from the latched registers.
  - Exactly one cycle, then go to CAPTURE.
- CAPTURE:
  - MemEn = 0.
  - On a read, MemRData is registered into RspData at the end of this cycle.
  - On a write, RspData holds its previous value.
- RESP:
  - RspValid[GrantId] = 1 for exactly one cycle; RspData is stable.
  - Then go to IDLE.
- Latency: ReqReady cycle to RspValid = 3 cycles. Maximum throughput = one access per 4 cycles.
- Requester obligations:
  - Hold ReqValid, ReqRW, ReqAddr and ReqWData stable until ReqReady is seen.
  - Inputs are ignored after acceptance until the next IDLE.
  - Dropping ReqValid before ReqReady withdraws the request with no side effects.
- Simultaneous requests:
  - Exactly one grant per IDLE cycle.
  - A requester that is continuously valid is served within NREQ transactions (no starvation).
- Re-request: a requester may reassert ReqValid during RESP; it is arbitrated in the following IDLE, where it has the lowest priority.
- Reset mid-operation:
  - The transaction is abandoned; no RspValid is produced.
  - MemEn is 0 from the cycle after Reset is sampled.
  - A memory write already strobed in ACCESS is not undone.
- Outside ACCESS: MemSelect, MemRW and MemWData hold their last values; MemEn is the only qualifier.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN
- Defined:
  - Adds input ReqLock (NREQ bits).
  - If ReqLock[GrantId] was high when that requester's request was accepted, and ReqValid[GrantId] is high in the next IDLE, the arbiter regrants the same requester, bypassing rotation. This supports atomic read-modify-write sequences.
  - The lock releases when ReqLock or ReqValid is low in IDLE; normal rotation then resumes from GrantId+1.
- Undefined: port absent; pure round-robin.

Decomposition:
- Package mem_arb_pkg:
  - State enum typedef (IDLE, ACCESS, CAPTURE, RESP).
  - RW encoding constants RW_READ = 0, RW_WRITE = 1.
  - clog2-based GrantId width function.
- One sub-module: rr_picker.
  - Combinational: inputs request vector and pointer; outputs one-hot grant, grant index and any-valid.
  - Reused for future bus arbiters.

Test Plan:
- Reset: assert Reset for 2 cycles mid-ACCESS -> next cycle MemEn = 0, Busy = 0, no RspValid; RspData = 0.
- Single write then read from requester 0:
  - Write addr 2, data 0xA5 -> ReqReady[0] in cycle t; MemEn=1, MemRW=1, MemSelect=2, MemWData=0xA5 at t+1; RspValid[0] at t+3.
  - Read addr 2 -> RspData = 0xA5 with RspValid[0].
- Contention: both requesters valid continuously after reset -> grant order 0,1,0,1; each RspValid 4 cycles apart.
- Withdrawal: requester 1 asserts ReqValid for one cycle while the arbiter is busy -> never granted; MemEn never asserted for its address.
- Back-to-back re-request:
  - Requester 0 reasserts during RESP while requester 1 is idle -> granted in the next IDLE, 4-cycle spacing.
  - Same with requester 1 valid -> requester 1 is granted first.
- MEM_ARB_LOCK_EN: requester 0 locks a read(addr 1) then write(addr 1, 0x3C) while requester 1 is valid -> both requester 0 accesses complete before requester 1's ReqReady.
